mos6502_interrupt_sequencer: RTL and testbench
==============================================

Name: mos6502_interrupt_sequencer

Overview:
- Downstream consumer of the 6502 interrupt request latch. Takes its T0-sampled requests (nNMI_T0, nIRQ_T0) plus reset and decoded BRK.
- Runs the 7-cycle interrupt/BRK/reset sequence.
- Drives the control overrides the core datapath needs during that sequence: opcode substitution, PC-increment inhibit, write inhibit, B-flag value, vector low byte, I-flag set and NMI acknowledge.
- Sits between the interrupt latch and the core's timing/decode logic.

Parameters:
- VEC_NMI, 8'hFA, low byte of NMI vector address (high byte fixed 8'hFF).
- VEC_RESET, 8'hFC, low byte of reset vector address.
- VEC_IRQ, 8'hFE, low byte of IRQ/BRK vector address.
- HIJACK_EN, 1, allow NMI to take over the vector of an in-flight IRQ/BRK sequence.

Ports:
- clk  in  1  CPU clock.
- RESET  in  1  Asynchronous active-high reset, one clock domain; also arms the reset sequence.
- NEXT_T  in  1  Cycle advance enable; all state updates are qualified by it.
- T0  in  1  Current cycle is the last cycle of an instruction (next cycle is an opcode fetch).
- nNMI_T0  in  1  Active-low pending NMI, sampled at T0.
- nIRQ_T0  in  1  Active-low pending IRQ (already I-masked), sampled at T0.
- BRK_op  in  1  Decoder flags the fetched opcode as 0x00 in T1 of a normal instruction.
- seq_active  out  1  High during sequence cycles T1..T6.
- seq_cycle  out  3  Sequence step 1..6; 0 when idle.
- force_brk  out  1  Replace fetched opcode with 0x00 (T1 of hardware sequence).
- inhibit_pc_inc  out  1  Suppress PC increment (T1 of hardware sequence).
- inhibit_write  out  1  Convert stack writes to reads (reset sequence T2..T4).
- push_b  out  1  B bit pushed at T4: 1 for BRK, 0 for IRQ/NMI.
- vec_lo  out  8  Vector address low byte; T5 uses vec_lo, T6 uses vec_lo|1.
- set_I  out  1  One-cycle pulse in T6: set the I flag.
- nmi_ack  out  1  One-cycle pulse clearing the upstream NMI edge latch.
- src  out  2  Latched source: 0 none, 1 reset, 2 NMI, 3 IRQ/BRK.

Behaviour:
- Reset (RESET=1, asynchronous):
  - Every output is 0; seq_cycle=0, src=0.
  - Internal rst_pend=1; state=IDLE.
- Start of sequence:
  - In IDLE, if rst_pend=1 and NEXT_T=1, enter T1 with src=1. T0 is not required.
  - Otherwise, when T0=1 and NEXT_T=1, pick by priority reset > NMI (nNMI_T0=0) > IRQ (nIRQ_T0=0). Enter T1 next cycle with that src.
  - If no request, stay IDLE. A BRK decode (BRK_op=1 while IDLE) enters T2 next cycle with src=3 and push_b=1. Its T1 was the real fetch, so no opcode force and PC increments.
- Step: seq_cycle advances 1→6 only on NEXT_T=1. With NEXT_T=0 every state and output holds; pulses are not repeated.
- Per cycle:
  - T1: force_brk=1 and inhibit_pc_inc=1 (hardware sources only).
  - T2..T4: stack pushes. inhibit_write=1 when src=1.
  - T4: push_b valid.
  - T5: vec_lo valid.
  - T6: set_I pulses. On the next advanced cycle, return to IDLE, clear rst_pend if src was 1, and set src=0.
- Vector: vec_lo = VEC_RESET/VEC_NMI/VEC_IRQ per src. It is latched on the advancing edge leaving T4.
- Hijack: if HIJACK_EN=1, src=3, and nNMI_T0=0 at any advanced cycle T1..T4, then src becomes 2 at T4 exit and vec_lo becomes VEC_NMI. push_b keeps its original value.
- nmi_ack: one-cycle pulse on the advancing edge leaving T4 whenever the final src=2 (normal or hijack).
- Simultaneous events:
  - Reset pending beats everything.
  - An NMI arriving during a reset sequence is not hijacked; it is taken at the next T0.
  - IRQ during a sequence is ignored; it is re-evaluated at the next T0.
- RESET mid-sequence aborts immediately to reset state; no pulses are emitted.

Decomposition:
- Shared package mos6502_pkg: src encodings (SRC_NONE/RESET/NMI/IRQ), vector low-byte constants, sequence step constants.
- No sub-module: single FSM plus step counter.

Test Plan:
- RESET high 3 cycles, then low with NEXT_T=1 → seq_cycle 1..6 on successive cycles; inhibit_write=1 in steps 2–4; vec_lo=8'hFC at step 5; set_I pulses at 6; nmi_ack never asserts.
- nIRQ_T0=0 with T0=1 → next cycle force_brk=1 and inhibit_pc_inc=1; push_b=0 at step 4; vec_lo=8'hFE; seq_active for exactly 6 advanced cycles.
- nNMI_T0=0 and nIRQ_T0=0 together at T0 → src=2, vec_lo=8'hFA, nmi_ack pulses exactly once leaving step 4.
- BRK_op=1 idle, then nNMI_T0=0 at step 3 → sequence starts at step 2 with push_b=1; vec_lo=8'hFA; nmi_ack=1 once. With HIJACK_EN=0 → vec_lo=8'hFE and no nmi_ack.
- IRQ sequence with NEXT_T toggled 0 every other cycle → steps hold during stalls; total 12 clocks; set_I is a single pulse.
- RESET asserted at step 3 of an NMI sequence → all outputs 0 asynchronously, no nmi_ack; after release a full reset sequence runs with vec_lo=8'hFC.

Source files
------------

// File: rtl/mos6502_pkg.sv
// Shared definitions for the 6502 interrupt sequencer.
//   src_t   : latched interrupt source (none / reset / NMI / IRQ-or-BRK)
//   state_t : sequence step; the encoding equals the externally visible
//             seq_cycle value (0 = idle, 1..6 = T1..T6)
//   DEF_VEC_* : default vector low bytes (vector high byte is always 8'hFF)
package mos6502_pkg;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_RESET = 2'd1,
    SRC_NMI   = 2'd2,
    SRC_IRQ   = 2'd3
  } src_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6
  } state_t;

  localparam logic [7:0] DEF_VEC_NMI   = 8'hFA;
  localparam logic [7:0] DEF_VEC_RESET = 8'hFC;
  localparam logic [7:0] DEF_VEC_IRQ   = 8'hFE;

  // Vector low byte for a given source.
  function automatic logic [7:0] vec_for(input src_t s,
                                         input logic [7:0] v_nmi,
                                         input logic [7:0] v_rst,
                                         input logic [7:0] v_irq);
    logic [7:0] v;
    v = 8'h00;
    case (s)
      SRC_RESET: v = v_rst;
      SRC_NMI:   v = v_nmi;
      SRC_IRQ:   v = v_irq;
      default:   v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mos6502_interrupt_sequencer.sv
// 6502 interrupt / BRK / reset sequencer.
// Consumes the T0-sampled interrupt requests and the decoded BRK opcode and
// walks the T1..T6 sequence, driving the datapath overrides.
// Ports:
//   clk, RESET (async, active high; also arms the reset sequence)
//   NEXT_T      : cycle advance enable, qualifies every state update
//   T0          : last cycle of an instruction
//   nNMI_T0/nIRQ_T0 : active-low requests sampled at T0
//   BRK_op      : fetched opcode is BRK (T1 of a normal instruction)
//   seq_active/seq_cycle : sequence status (0 when idle)
//   force_brk/inhibit_pc_inc : T1 of hardware sequences
//   inhibit_write : reset sequence T2..T4 (stack writes become reads)
//   push_b      : B flag value for the status push
//   vec_lo      : vector low byte, valid in T5/T6
//   set_I, nmi_ack : single-clock pulses
//   src         : latched source
module mos6502_interrupt_sequencer
  import mos6502_pkg::*;
#(
  parameter logic [7:0] VEC_NMI   = DEF_VEC_NMI,
  parameter logic [7:0] VEC_RESET = DEF_VEC_RESET,
  parameter logic [7:0] VEC_IRQ   = DEF_VEC_IRQ,
  parameter bit         HIJACK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       NEXT_T,
  input  logic       T0,
  input  logic       nNMI_T0,
  input  logic       nIRQ_T0,
  input  logic       BRK_op,
  output logic       seq_active,
  output logic [2:0] seq_cycle,
  output logic       force_brk,
  output logic       inhibit_pc_inc,
  output logic       inhibit_write,
  output logic       push_b,
  output logic [7:0] vec_lo,
  output logic       set_I,
  output logic       nmi_ack,
  output logic [1:0] src
);

  state_t     state;
  src_t       src_reg;
  logic       rst_pend;
  logic       brk_reg;
  logic       nmi_seen;
  logic [7:0] vec_reg;
  logic       set_i_reg;
  logic       nmi_ack_reg;

  logic nmi_req;
  logic irq_req;
  logic hijack_now;
  src_t final_src;

  assign nmi_req = ~nNMI_T0;
  assign irq_req = ~nIRQ_T0;

  // An NMI seen while an IRQ/BRK sequence is still pushing steals its vector.
  assign hijack_now = HIJACK_EN && (src_reg == SRC_IRQ) && nmi_req;
  assign final_src  = (nmi_seen || hijack_now) ? SRC_NMI : src_reg;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      src_reg     <= SRC_NONE;
      rst_pend    <= 1'b1;
      brk_reg     <= 1'b0;
      nmi_seen    <= 1'b0;
      vec_reg     <= 8'h00;
      set_i_reg   <= 1'b0;
      nmi_ack_reg <= 1'b0;
    end else begin
      // Pulses last exactly one clock, even if the next cycle is stalled.
      set_i_reg   <= 1'b0;
      nmi_ack_reg <= 1'b0;
      if (NEXT_T) begin
        case (state)
          ST_IDLE: begin
            if (rst_pend) begin
              state   <= ST_T1;
              src_reg <= SRC_RESET;
            end else if (T0 && nmi_req) begin
              state   <= ST_T1;
              src_reg <= SRC_NMI;
            end else if (T0 && irq_req) begin
              state   <= ST_T1;
              src_reg <= SRC_IRQ;
            end else if (BRK_op) begin
              // The real opcode fetch already was T1, so join at T2.
              state   <= ST_T2;
              src_reg <= SRC_IRQ;
              brk_reg <= 1'b1;
            end
          end
          ST_T1: begin
            if (hijack_now) nmi_seen <= 1'b1;
            state <= ST_T2;
          end
          ST_T2: begin
            if (hijack_now) nmi_seen <= 1'b1;
            state <= ST_T3;
          end
          ST_T3: begin
            if (hijack_now) nmi_seen <= 1'b1;
            state <= ST_T4;
          end
          ST_T4: begin
            state       <= ST_T5;
            src_reg     <= final_src;
            vec_reg     <= vec_for(final_src, VEC_NMI, VEC_RESET, VEC_IRQ);
            nmi_ack_reg <= (final_src == SRC_NMI);
          end
          ST_T5: begin
            state     <= ST_T6;
            set_i_reg <= 1'b1;
          end
          ST_T6: begin
            if (src_reg == SRC_RESET) rst_pend <= 1'b0;
            state    <= ST_IDLE;
            src_reg  <= SRC_NONE;
            brk_reg  <= 1'b0;
            nmi_seen <= 1'b0;
            vec_reg  <= 8'h00;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign seq_cycle      = state;
  assign seq_active     = (state != ST_IDLE);
  assign force_brk      = (state == ST_T1);
  assign inhibit_pc_inc = (state == ST_T1);
  assign inhibit_write  = (src_reg == SRC_RESET) &&
                          ((state == ST_T2) || (state == ST_T3) || (state == ST_T4));
  assign push_b         = brk_reg;
  assign vec_lo         = vec_reg;
  assign set_I          = set_i_reg;
  assign nmi_ack        = nmi_ack_reg;
  assign src            = src_reg;

endmodule

// File: tb/tb_mos6502_interrupt_sequencer.sv
module tb_mos6502_interrupt_sequencer;

  logic clk = 1'b0;
  logic RESET, NEXT_T, T0, nNMI_T0, nIRQ_T0, BRK_op;

  // Index 0: HIJACK_EN=1, index 1: HIJACK_EN=0.
  logic       seq_active_o [2];
  logic [2:0] seq_cycle_o  [2];
  logic       force_brk_o  [2];
  logic       inh_pc_o     [2];
  logic       inh_wr_o     [2];
  logic       push_b_o     [2];
  logic [7:0] vec_lo_o     [2];
  logic       set_i_o      [2];
  logic       nmi_ack_o    [2];
  logic [1:0] src_o        [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mos6502_interrupt_sequencer #(.HIJACK_EN(1'b1)) dut (
    .clk(clk), .RESET(RESET), .NEXT_T(NEXT_T), .T0(T0),
    .nNMI_T0(nNMI_T0), .nIRQ_T0(nIRQ_T0), .BRK_op(BRK_op),
    .seq_active(seq_active_o[0]), .seq_cycle(seq_cycle_o[0]),
    .force_brk(force_brk_o[0]), .inhibit_pc_inc(inh_pc_o[0]),
    .inhibit_write(inh_wr_o[0]), .push_b(push_b_o[0]), .vec_lo(vec_lo_o[0]),
    .set_I(set_i_o[0]), .nmi_ack(nmi_ack_o[0]), .src(src_o[0]));

  mos6502_interrupt_sequencer #(.HIJACK_EN(1'b0)) dut_nh (
    .clk(clk), .RESET(RESET), .NEXT_T(NEXT_T), .T0(T0),
    .nNMI_T0(nNMI_T0), .nIRQ_T0(nIRQ_T0), .BRK_op(BRK_op),
    .seq_active(seq_active_o[1]), .seq_cycle(seq_cycle_o[1]),
    .force_brk(force_brk_o[1]), .inhibit_pc_inc(inh_pc_o[1]),
    .inhibit_write(inh_wr_o[1]), .push_b(push_b_o[1]), .vec_lo(vec_lo_o[1]),
    .set_I(set_i_o[1]), .nmi_ack(nmi_ack_o[1]), .src(src_o[1]));

  // Behavioural model: step position, source, BRK flag, "NMI seen during
  // pushes", pending reset, vector and the two pulses.
  int m_pos [2];
  int m_src [2];
  int m_brk [2];
  int m_seen[2];
  int m_rst [2];
  int m_vec [2];
  int m_seti[2];
  int m_ack [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int vec_of(input int s);
    if (s == 1) return 'hFC;
    if (s == 2) return 'hFA;
    return 'hFE;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pos[d] = 0; m_src[d] = 0; m_brk[d] = 0; m_seen[d] = 0;
      m_rst[d] = 1; m_vec[d] = 0; m_seti[d] = 0; m_ack[d] = 0;
    end
  endtask

  task automatic model_step(input bit nt, input bit t0, input bit nn,
                            input bit ni, input bit brk);
    for (int d = 0; d < 2; d++) begin
      bit hit;
      m_seti[d] = 0;
      m_ack[d]  = 0;
      if (nt) begin
        hit = (d == 0) && (m_src[d] == 3) && !nn;
        if (m_pos[d] == 0) begin
          if (m_rst[d] != 0)       begin m_pos[d] = 1; m_src[d] = 1; end
          else if (t0 && !nn)      begin m_pos[d] = 1; m_src[d] = 2; end
          else if (t0 && !ni)      begin m_pos[d] = 1; m_src[d] = 3; end
          else if (brk)            begin m_pos[d] = 2; m_src[d] = 3; m_brk[d] = 1; end
        end else if (m_pos[d] < 4) begin
          if (hit) m_seen[d] = 1;
          m_pos[d]++;
        end else if (m_pos[d] == 4) begin
          if (hit || m_seen[d] != 0) m_src[d] = 2;
          m_vec[d] = vec_of(m_src[d]);
          m_ack[d] = (m_src[d] == 2) ? 1 : 0;
          m_pos[d] = 5;
        end else if (m_pos[d] == 5) begin
          m_seti[d] = 1;
          m_pos[d]  = 6;
        end else begin
          if (m_src[d] == 1) m_rst[d] = 0;
          m_pos[d] = 0; m_src[d] = 0; m_brk[d] = 0; m_seen[d] = 0; m_vec[d] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      int p;
      p = m_pos[d];
      chk($sformatf("seq_active[%0d]", d), int'(seq_active_o[d]), (p != 0) ? 1 : 0);
      chk($sformatf("seq_cycle[%0d]", d), int'(seq_cycle_o[d]), p);
      chk($sformatf("force_brk[%0d]", d), int'(force_brk_o[d]), (p == 1) ? 1 : 0);
      chk($sformatf("inhibit_pc_inc[%0d]", d), int'(inh_pc_o[d]), (p == 1) ? 1 : 0);
      chk($sformatf("inhibit_write[%0d]", d), int'(inh_wr_o[d]),
          (m_src[d] == 1 && p >= 2 && p <= 4) ? 1 : 0);
      chk($sformatf("push_b[%0d]", d), int'(push_b_o[d]), m_brk[d]);
      chk($sformatf("vec_lo[%0d]", d), int'(vec_lo_o[d]), m_vec[d]);
      chk($sformatf("set_I[%0d]", d), int'(set_i_o[d]), m_seti[d]);
      chk($sformatf("nmi_ack[%0d]", d), int'(nmi_ack_o[d]), m_ack[d]);
      chk($sformatf("src[%0d]", d), int'(src_o[d]), m_src[d]);
    end
  endtask

  // Drive one clock of inputs (from a negedge), advance the model, compare.
  task automatic cyc(input bit rst, input bit nt, input bit t0, input bit nn,
                     input bit ni, input bit brk);
    RESET = rst; NEXT_T = nt; T0 = t0; nNMI_T0 = nn; nIRQ_T0 = ni; BRK_op = brk;
    if (rst) model_reset();
    else     model_step(nt, t0, nn, ni, brk);
    @(posedge clk);
    @(negedge clk);
    compare_all();
    $display("cyc t=%0t rst=%0b nt=%0b t0=%0b nn=%0b ni=%0b brk=%0b -> step=%0d src=%0d vec=%02h",
             $time, rst, nt, t0, nn, ni, brk, seq_cycle_o[0], src_o[0], vec_lo_o[0]);
  endtask

  initial begin
    int cnt_a, cnt_b;
    RESET = 1'b1; NEXT_T = 1'b0; T0 = 1'b0; nNMI_T0 = 1'b1; nIRQ_T0 = 1'b1; BRK_op = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset sequence.
    repeat (3) cyc(1, 1, 0, 1, 1, 0);
    chk("lit_reset_idle", int'(seq_cycle_o[0]), 0);
    chk("lit_reset_src", int'(src_o[0]), 0);
    cnt_a = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc(0, 1, 0, 1, 1, 0);
      chk("lit_rst_step", int'(seq_cycle_o[0]), k);
      if (k >= 2 && k <= 4) chk("lit_rst_inhwr", int'(inh_wr_o[0]), 1);
      if (k == 5) chk("lit_rst_vec", int'(vec_lo_o[0]), 'hFC);
      if (k == 6) chk("lit_rst_setI", int'(set_i_o[0]), 1);
      cnt_a += int'(nmi_ack_o[0]);
    end
    chk("lit_rst_noack", cnt_a, 0);
    cyc(0, 1, 0, 1, 1, 0);
    chk("lit_rst_done", int'(seq_active_o[0]), 0);

    // IRQ sequence.
    cyc(0, 1, 1, 1, 0, 0);
    chk("lit_irq_force", int'(force_brk_o[0]), 1);
    chk("lit_irq_inhpc", int'(inh_pc_o[0]), 1);
    cnt_a = 1;
    for (int k = 2; k <= 7; k++) begin
      cyc(0, 1, 0, 1, 1, 0);
      cnt_a += int'(seq_active_o[0]);
      if (k == 4) chk("lit_irq_pushb", int'(push_b_o[0]), 0);
      if (k == 5) chk("lit_irq_vec", int'(vec_lo_o[0]), 'hFE);
    end
    chk("lit_irq_len", cnt_a, 6);

    // NMI and IRQ together: NMI wins.
    cyc(0, 1, 1, 0, 0, 0);
    chk("lit_nmi_src", int'(src_o[0]), 2);
    cnt_a = 0;
    for (int k = 2; k <= 7; k++) begin
      cyc(0, 1, 0, 1, 1, 0);
      cnt_a += int'(nmi_ack_o[0]);
      if (k == 5) begin
        chk("lit_nmi_vec", int'(vec_lo_o[0]), 'hFA);
        chk("lit_nmi_ack", int'(nmi_ack_o[0]), 1);
      end
    end
    chk("lit_nmi_ackcnt", cnt_a, 1);

    // BRK hijacked by NMI at step 3.
    cyc(0, 1, 0, 1, 1, 1);
    chk("lit_brk_step", int'(seq_cycle_o[0]), 2);
    chk("lit_brk_pushb", int'(push_b_o[0]), 1);
    chk("lit_brk_noforce", int'(force_brk_o[0]), 0);
    cyc(0, 1, 0, 1, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 1, 0);
    chk("lit_hij_vec", int'(vec_lo_o[0]), 'hFA);
    chk("lit_hij_ack", int'(nmi_ack_o[0]), 1);
    chk("lit_nohij_vec", int'(vec_lo_o[1]), 'hFE);
    chk("lit_nohij_ack", int'(nmi_ack_o[1]), 0);
    chk("lit_hij_pushb", int'(push_b_o[0]), 1);
    repeat (2) cyc(0, 1, 0, 1, 1, 0);

    // IRQ with stalls every other cycle.
    cyc(0, 1, 1, 1, 0, 0);
    cnt_a = 1; cnt_b = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(0, (i % 2) == 1, 0, 1, 1, 0);
      cnt_a += int'(seq_active_o[0]);
      cnt_b += int'(set_i_o[0]);
    end
    chk("lit_stall_len", cnt_a, 12);
    chk("lit_stall_setI", cnt_b, 1);

    // RESET at step 3 of an NMI sequence.
    cyc(0, 1, 1, 0, 1, 0);
    repeat (2) cyc(0, 1, 0, 1, 1, 0);
    chk("lit_pre_abort", int'(seq_cycle_o[0]), 3);
    RESET = 1'b1;
    #1;
    chk("lit_async_active", int'(seq_active_o[0]), 0);
    chk("lit_async_src", int'(src_o[0]), 0);
    model_reset();
    @(negedge clk);
    compare_all();
    cyc(1, 1, 0, 1, 1, 0);
    cnt_a = 0;
    for (int k = 1; k <= 7; k++) begin
      cyc(0, 1, 0, 1, 1, 0);
      cnt_a += int'(nmi_ack_o[0]);
      if (k == 5) chk("lit_rerst_vec", int'(vec_lo_o[0]), 'hFC);
    end
    chk("lit_rerst_noack", cnt_a, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) != 0,
          $urandom_range(0, 4) != 0,
          $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
